// File: rtl/ternary_nand_checker.sv
// Stimulus/response checker for a 2-bit-encoded ternary NAND gate: walks all nine
// (A,B) trit pairs, samples the gate output after a settle window, and scores it.
module ternary_nand_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] c_i,
    output logic [1:0] a_o,
    output logic [1:0] b_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [3:0] first_err_idx,
    output logic       invalid_seen
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);
    localparam logic [3:0] LAST_VEC    = 4'd8;
    localparam logic [3:0] NO_ERR_IDX  = 4'hF;
    localparam logic [1:0] TRIT_BAD    = 2'b11;

    state_t     state_q, state_d;
    logic [3:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] err_q, err_d;
    logic [3:0] first_q, first_d;
    logic       inv_q, inv_d;
    logic       pass_q, pass_d;

    logic [1:0] vec_a, vec_b;
    logic [1:0] expected;
    logic       mismatch;

    // Vector index k = 3*A + B, A-major.
    function automatic logic [3:0] vec_trits(input logic [3:0] k);
        logic [3:0] ab;
        case (k)
            4'd0:    ab = {2'd0, 2'd0};
            4'd1:    ab = {2'd0, 2'd1};
            4'd2:    ab = {2'd0, 2'd2};
            4'd3:    ab = {2'd1, 2'd0};
            4'd4:    ab = {2'd1, 2'd1};
            4'd5:    ab = {2'd1, 2'd2};
            4'd6:    ab = {2'd2, 2'd0};
            4'd7:    ab = {2'd2, 2'd1};
            4'd8:    ab = {2'd2, 2'd2};
            default: ab = {2'd0, 2'd0};
        endcase
        return ab;
    endfunction

    // Ternary NAND: 2 - min(A,B); never yields the invalid code.
    function automatic logic [1:0] ternary_nand(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] lo;
        lo = (a < b) ? a : b;
        case (lo)
            2'd0:    return 2'd2;
            2'd1:    return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    assign {vec_a, vec_b} = vec_trits(vec_q);
    assign expected       = ternary_nand(vec_a, vec_b);
    assign mismatch       = (c_i != expected);

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        first_d = first_q;
        inv_d   = inv_q;
        pass_d  = pass_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_APPLY;
                    vec_d   = 4'd0;
                    cnt_d   = 4'd0;
                    err_d   = 4'd0;
                    first_d = NO_ERR_IDX;
                    inv_d   = 1'b0;
                    pass_d  = 1'b0;
                end
            end

            S_APPLY: begin
                if (cnt_q == SETTLE_LAST) begin
                    if (mismatch) begin
                        err_d = err_q + 4'd1;
                        if (first_q == NO_ERR_IDX) begin
                            first_d = vec_q;
                        end
                    end
                    if (c_i == TRIT_BAD) begin
                        inv_d = 1'b1;
                    end
                    // pass uses the count including this last sample.
                    if (vec_q == LAST_VEC) begin
                        state_d = S_DONE;
                        pass_d  = (err_d == 4'd0);
                    end else begin
                        vec_d = vec_q + 4'd1;
                        cnt_d = 4'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= 4'd0;
            cnt_q   <= 4'd0;
            err_q   <= 4'd0;
            first_q <= NO_ERR_IDX;
            inv_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            first_q <= first_d;
            inv_q   <= inv_d;
            pass_q  <= pass_d;
        end
    end

    // The gate inputs idle at 00 outside a run.
    assign a_o           = (state_q == S_APPLY) ? vec_a : 2'b00;
    assign b_o           = (state_q == S_APPLY) ? vec_b : 2'b00;
    assign busy          = (state_q == S_APPLY);
    assign done          = (state_q == S_DONE);
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;
    assign invalid_seen  = inv_q;

endmodule

// File: tb/tb_ternary_nand_checker.sv
// Directed bench for ternary_nand_checker: a behavioural gate with selectable faults
// answers the checker; results are compared against hand-computed constants.
module tb_ternary_nand_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start1;
    logic [1:0] c, c1;
    logic [1:0] a_o, b_o, a1, b1;
    logic       busy, done, pass, inv;
    logic       busy1, done1, pass1, inv1;
    logic [3:0] err_count, first_idx, err1, first1;
    int         fault;
    int         n_cmp = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    ternary_nand_checker #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .c_i(c),
        .a_o(a_o), .b_o(b_o), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_idx), .invalid_seen(inv)
    );

    ternary_nand_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .c_i(c1),
        .a_o(a1), .b_o(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_idx(first1), .invalid_seen(inv1)
    );

    function automatic logic [1:0] good_nand(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] lo;
        lo = (a < b) ? a : b;
        return 2'd2 - lo;
    endfunction

    // Gate model: 0 correct, 1 stuck 00, 2 stuck 11, 3 wrong (2) only at (1,1).
    always_comb begin
        c = good_nand(a_o, b_o);
        case (fault)
            1: c = 2'b00;
            2: c = 2'b11;
            3: if (a_o == 2'd1 && b_o == 2'd1) c = 2'd2;
            default: ;
        endcase
    end
    assign c1 = good_nand(a1, b1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " a_o"}, 8'(a_o), 8'h0);
        check({tag, " b_o"}, 8'(b_o), 8'h0);
        check({tag, " busy"}, 8'(busy), 8'h0);
        check({tag, " done"}, 8'(done), 8'h0);
        check({tag, " pass"}, 8'(pass), 8'h0);
        check({tag, " err_count"}, 8'(err_count), 8'h0);
        check({tag, " first_idx"}, 8'(first_idx), 8'hF);
        check({tag, " invalid"}, 8'(inv), 8'h0);
    endtask

    // Full run on the SETTLE=2 instance: 9 vectors x 3 cycles, then final results.
    task automatic run(input string tag, input int mode, input bit restart,
                       input logic [3:0] e_err, input logic [3:0] e_first,
                       input logic e_inv, input logic e_pass);
        int idx;
        fault = mode;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " cleared err"}, 8'(err_count), 8'h0);
        check({tag, " cleared first"}, 8'(first_idx), 8'hF);
        check({tag, " cleared pass"}, 8'(pass), 8'h0);
        for (int j = 0; j < 27; j++) begin
            idx = j / 3;
            check({tag, " a_o"}, 8'(a_o), 8'(idx / 3));
            check({tag, " b_o"}, 8'(b_o), 8'(idx % 3));
            check({tag, " busy"}, 8'(busy), 8'h1);
            check({tag, " done early"}, 8'(done), 8'h0);
            start = restart && (j == 9);
            tick();
        end
        start = 1'b0;
        check({tag, " done"}, 8'(done), 8'h1);
        check({tag, " busy end"}, 8'(busy), 8'h0);
        check({tag, " pass"}, 8'(pass), 8'(e_pass));
        check({tag, " err_count"}, 8'(err_count), 8'(e_err));
        check({tag, " first_idx"}, 8'(first_idx), 8'(e_first));
        check({tag, " invalid"}, 8'(inv), 8'(e_inv));
        check({tag, " a_o idle"}, 8'(a_o), 8'h0);
        check({tag, " b_o idle"}, 8'(b_o), 8'h0);
        tick();
        check({tag, " done held"}, 8'(done), 8'h1);
    endtask

    initial begin
        fault  = 0;
        start  = 1'b0;
        start1 = 1'b0;
        rst    = 1'b1;
        tick();
        check_reset_values("reset");
        check("reset dut1 busy", 8'(busy1), 8'h0);
        check("reset dut1 first", 8'(first1), 8'hF);
        rst = 1'b0;
        tick();

        run("good", 0, 1'b0, 4'd0, 4'hF, 1'b0, 1'b1);
        run("stuck00", 1, 1'b0, 4'd8, 4'd0, 1'b0, 1'b0);
        run("stuck11", 2, 1'b0, 4'd9, 4'd0, 1'b1, 1'b0);
        run("fault11", 3, 1'b0, 4'd1, 4'd4, 1'b0, 1'b0);
        run("rerun", 0, 1'b0, 4'd0, 4'hF, 1'b0, 1'b1);
        run("restart_ignored", 0, 1'b1, 4'd0, 4'hF, 1'b0, 1'b1);

        // Reset mid-run, with start also high to show reset wins.
        fault = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        check("midrun busy", 8'(busy), 8'h1);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        check_reset_values("midrun rst");
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("after rst idle", 8'(busy), 8'h0);
        run("after_rst", 0, 1'b0, 4'd0, 4'hF, 1'b0, 1'b1);

        // SETTLE_CYCLES = 1: 2 cycles per vector, done after 18 cycles.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int j = 0; j < 18; j++) begin
            check("s1 a_o", 8'(a1), 8'((j / 2) / 3));
            check("s1 b_o", 8'(b1), 8'((j / 2) % 3));
            check("s1 done early", 8'(done1), 8'h0);
            tick();
        end
        check("s1 done", 8'(done1), 8'h1);
        check("s1 busy", 8'(busy1), 8'h0);
        check("s1 pass", 8'(pass1), 8'h1);
        check("s1 err_count", 8'(err1), 8'h0);
        check("s1 invalid", 8'(inv1), 8'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
